keypad_operand_sequencer: RTL and testbench

// Parametrised keypad-entry sequencer for the Booth multiplier datapath. Collects multi-digit

---
 rtl/keypad_operand_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_operand_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_operand_sequencer.sv
// Keypad entry sequencer: operand A, multiply key, operand B, '=' starts multiplier.
// Optional inactivity timeout enabled by defining KEY_TIMEOUT_EN.
module keypad_operand_sequencer #(
  parameter int DIGITS         = 2,
  parameter int RADIX          = 10,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_pressed,
  input  logic [3:0]                   key_code,
  input  logic [2:0]                   key_class,
  input  logic                         op_done,
  output logic                         load_a,
  output logic                         load_b,
  output logic [3:0]                   digit_out,
  output logic                         clear_operands,
  output logic                         op_start,
  output logic                         result_valid,
  output logic [$clog2(DIGITS+1)-1:0]  cnt_a,
  output logic [$clog2(DIGITS+1)-1:0]  cnt_b,
  output logic [2:0]                   state_o,
  output logic                         timeout_o
);

  localparam int CW = $clog2(DIGITS+1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OPA  = 3'd1,
    S_SIGN = 3'd2,
    S_OPB  = 3'd3,
    S_RUN  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic            r_key_prev;
  logic            r_load_a, r_load_b, r_clr, r_start;
  logic            w_load_a_n, w_load_b_n, w_clr_n, w_start_n;
  logic [3:0]      r_digit, w_digit_n;
  logic [CW-1:0]   r_cnt_a, r_cnt_b, w_cnt_a_n, w_cnt_b_n;

  logic w_press, w_dig, w_mul, w_eq, w_clr;

  assign w_press = key_pressed & ~r_key_prev;
  assign w_dig   = w_press && key_class == 3'b000
                   && {28'd0, key_code} < 32'(RADIX);
  assign w_mul   = w_press && key_class == 3'b001;
  assign w_eq    = w_press && key_class == 3'b111;
  assign w_clr   = w_press && key_class == 3'b010;

`ifdef KEY_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_idle, w_idle_n;
  logic          r_to, w_to_n;
  logic          w_armed;

  assign w_armed = r_state == S_OPA || r_state == S_SIGN
                   || r_state == S_OPB;
`endif

  always_comb begin
    w_state_n  = r_state;
    w_load_a_n = 1'b0;
    w_load_b_n = 1'b0;
    w_clr_n    = 1'b0;
    w_start_n  = 1'b0;
    w_digit_n  = r_digit;
    w_cnt_a_n  = r_cnt_a;
    w_cnt_b_n  = r_cnt_b;
    unique case (r_state)
      S_IDLE: begin
        if (w_dig) begin
          w_load_a_n = 1'b1;
          w_digit_n  = key_code;
          w_cnt_a_n  = CW'(1);
          w_state_n  = S_OPA;
        end
      end
      S_OPA: begin
        if (w_dig && r_cnt_a < CW'(DIGITS)) begin
          w_load_a_n = 1'b1;
          w_digit_n  = key_code;
          w_cnt_a_n  = r_cnt_a + CW'(1);
        end else if (w_mul) begin
          w_state_n  = S_SIGN;
        end
      end
      S_SIGN: begin
        if (w_dig) begin
          w_load_b_n = 1'b1;
          w_digit_n  = key_code;
          w_cnt_b_n  = CW'(1);
          w_state_n  = S_OPB;
        end
      end
      S_OPB: begin
        if (w_dig && r_cnt_b < CW'(DIGITS)) begin
          w_load_b_n = 1'b1;
          w_digit_n  = key_code;
          w_cnt_b_n  = r_cnt_b + CW'(1);
        end else if (w_eq) begin
          w_start_n  = 1'b1;
          w_state_n  = S_RUN;
        end
      end
      S_RUN: begin
        if (op_done) w_state_n = S_DONE;
      end
      S_DONE: begin
        if (w_dig) begin
          w_clr_n    = 1'b1;
          w_load_a_n = 1'b1;
          w_digit_n  = key_code;
          w_cnt_a_n  = CW'(1);
          w_cnt_b_n  = '0;
          w_state_n  = S_OPA;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    // clear outranks any digit handling, except while the multiplier runs
    if (w_clr && r_state != S_RUN) begin
      w_state_n  = S_IDLE;
      w_clr_n    = 1'b1;
      w_load_a_n = 1'b0;
      w_load_b_n = 1'b0;
      w_start_n  = 1'b0;
      w_digit_n  = r_digit;
      w_cnt_a_n  = '0;
      w_cnt_b_n  = '0;
    end
`ifdef KEY_TIMEOUT_EN
    w_idle_n = '0;
    w_to_n   = 1'b0;
    if (w_armed && !w_press) begin
      if (r_idle == TW'(TIMEOUT_CYCLES-1)) begin
        w_to_n    = 1'b1;
        w_clr_n   = 1'b1;
        w_cnt_a_n = '0;
        w_cnt_b_n = '0;
        w_state_n = S_IDLE;
      end else begin
        w_idle_n  = r_idle + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_key_prev <= 1'b0;
      r_load_a   <= 1'b0;
      r_load_b   <= 1'b0;
      r_clr      <= 1'b0;
      r_start    <= 1'b0;
      r_digit    <= '0;
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_key_prev <= key_pressed;
      r_load_a   <= w_load_a_n;
      r_load_b   <= w_load_b_n;
      r_clr      <= w_clr_n;
      r_start    <= w_start_n;
      r_digit    <= w_digit_n;
      r_cnt_a    <= w_cnt_a_n;
      r_cnt_b    <= w_cnt_b_n;
    end
  end

`ifdef KEY_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
      r_to   <= 1'b0;
    end else begin
      r_idle <= w_idle_n;
      r_to   <= w_to_n;
    end
  end

  assign timeout_o = r_to;
`else
  assign timeout_o = 1'b0;
`endif

  assign load_a         = r_load_a;
  assign load_b         = r_load_b;
  assign digit_out      = r_digit;
  assign clear_operands = r_clr;
  assign op_start       = r_start;
  assign result_valid   = r_state == S_DONE;
  assign cnt_a          = r_cnt_a;
  assign cnt_b          = r_cnt_b;
  assign state_o        = r_state;

endmodule

// File: tb/tb_keypad_operand_sequencer.sv
// Directed bench for keypad_operand_sequencer (DIGITS=2, RADIX=10, TIMEOUT_CYCLES=16).
// Timeout expectations follow whether KEY_TIMEOUT_EN is defined.
module tb_keypad_operand_sequencer;

  localparam int DIGITS = 2;
  localparam int CW     = $clog2(DIGITS+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_pressed = 1'b0;
  logic [3:0]    key_code = '0;
  logic [2:0]    key_class = '0;
  logic          op_done = 1'b0;
  logic          load_a, load_b, clear_operands, op_start;
  logic          result_valid, timeout_o;
  logic [3:0]    digit_out;
  logic [CW-1:0] cnt_a, cnt_b;
  logic [2:0]    state_o;

  int n_chk = 0;
  int n_err = 0;

  int la_cnt, lb_cnt, st_cnt, clr_cnt, to_cnt, both_cnt;
  logic [3:0] a_q[$];
  logic [3:0] b_q[$];

  keypad_operand_sequencer #(
    .DIGITS(DIGITS), .RADIX(10), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .key_pressed(key_pressed),
    .key_code(key_code), .key_class(key_class), .op_done(op_done),
    .load_a(load_a), .load_b(load_b), .digit_out(digit_out),
    .clear_operands(clear_operands), .op_start(op_start),
    .result_valid(result_valid), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .state_o(state_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_a) begin la_cnt++; a_q.push_back(digit_out); end
    if (load_b) begin lb_cnt++; b_q.push_back(digit_out); end
    if (op_start) st_cnt++;
    if (clear_operands) clr_cnt++;
    if (timeout_o) to_cnt++;
    if (clear_operands && load_a) both_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic zero_mon();
    la_cnt = 0; lb_cnt = 0; st_cnt = 0;
    clr_cnt = 0; to_cnt = 0; both_cnt = 0;
    a_q.delete(); b_q.delete();
  endtask

  task automatic key(input logic [2:0] c, input logic [3:0] k);
    @(negedge clk);
    key_pressed = 1'b1; key_class = c; key_code = k;
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic dig(input logic [3:0] k); key(3'b000, k); endtask

  task automatic pulse_done();
    @(negedge clk); op_done = 1'b1;
    @(negedge clk); op_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    zero_mon();
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    chk("rst_strobes", {load_a, load_b, clear_operands, op_start}, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_digit", digit_out, 0);
    chk("rst_timeout", timeout_o, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // 3 7 x 4 5 =
    zero_mon();
    dig(3); dig(7); key(3'b001, 0); dig(4); dig(5); key(3'b111, 0);
    chk("seq_la", la_cnt, 2);
    chk("seq_lb", lb_cnt, 2);
    chk("seq_a0", a_q.size() > 0 ? int'(a_q[0]) : -1, 3);
    chk("seq_a1", a_q.size() > 1 ? int'(a_q[1]) : -1, 7);
    chk("seq_b0", b_q.size() > 0 ? int'(b_q[0]) : -1, 4);
    chk("seq_b1", b_q.size() > 1 ? int'(b_q[1]) : -1, 5);
    chk("seq_cnts", {cnt_a, cnt_b}, {2'd2, 2'd2});
    chk("seq_start", st_cnt, 1);
    chk("seq_run", state_o, 4);
    chk("seq_valid_lo", result_valid, 0);
    pulse_done();
    chk("seq_done", state_o, 5);
    chk("seq_valid_hi", result_valid, 1);

    // clear, then 1 2 9 saturates; bad digit / unknown class in SIGN
    key(3'b010, 0);
    zero_mon();
    dig(1); dig(2); dig(9);
    chk("sat_la", la_cnt, 2);
    chk("sat_cnt_a", cnt_a, 2);
    chk("sat_digit", digit_out, 2);
    key(3'b001, 0);
    dig(12);
    chk("bad_dig_lb", lb_cnt, 0);
    chk("bad_dig_state", state_o, 2);
    key(3'b011, 4);
    key(3'b111, 0);
    chk("unk_state", state_o, 2);
    chk("unk_lb", lb_cnt, 0);

    // held key is one event
    key(3'b010, 0);
    zero_mon();
    @(negedge clk);
    key_pressed = 1'b1; key_class = 3'b000; key_code = 5;
    repeat (10) @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    chk("hold_la", la_cnt, 1);
    chk("hold_digit", digit_out, 5);
    chk("hold_cnt_a", cnt_a, 1);

    // clear in OPERAND_B, then clear in RUN ignored
    key(3'b001, 0); dig(4);
    chk("opb_state", state_o, 3);
    zero_mon();
    key(3'b010, 0);
    chk("clr_b_pulse", clr_cnt, 1);
    chk("clr_b_state", state_o, 0);
    chk("clr_b_cnts", {cnt_a, cnt_b}, 0);
    dig(1); key(3'b001, 0); dig(2); key(3'b111, 0);
    zero_mon();
    key(3'b010, 0);
    chk("run_clr_state", state_o, 4);
    chk("run_clr_pulse", clr_cnt, 0);
    @(negedge clk);
    op_done = 1'b1;
    key_pressed = 1'b1; key_class = 3'b000; key_code = 6;
    @(negedge clk);
    op_done = 1'b0; key_pressed = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_drop_state", state_o, 5);
    chk("done_drop_la", la_cnt, 0);
    key(3'b001, 0);
    chk("done_mul", state_o, 5);
    dig(8);
    chk("done_dig_both", both_cnt, 1);
    chk("done_dig_state", state_o, 1);
    chk("done_dig_cnts", {cnt_a, cnt_b}, {2'd1, 2'd0});
    chk("done_dig_val", digit_out, 8);

    // inactivity in OPERAND_A
    zero_mon();
    repeat (30) @(negedge clk);
`ifdef KEY_TIMEOUT_EN
    chk("to_pulse", to_cnt, 1);
    chk("to_clear", clr_cnt, 1);
    chk("to_state", state_o, 0);
    chk("to_cnt_a", cnt_a, 0);
`else
    chk("to_pulse", to_cnt, 0);
    chk("to_state", state_o, 1);
`endif

    // async reset while load_b strobe is high in OPERAND_B
    key(3'b010, 0);
    dig(2); key(3'b001, 0);
    @(negedge clk);
    key_pressed = 1'b1; key_class = 3'b000; key_code = 9;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", state_o, 0);
    chk("arst_cnts", {cnt_a, cnt_b}, 0);
    chk("arst_strobes", {load_a, load_b, clear_operands, op_start}, 0);
    chk("arst_digit", digit_out, 0);
    key_pressed = 1'b0;
    @(negedge clk); rst = 1'b1;
    zero_mon();
    repeat (5) @(negedge clk);
    chk("arst_no_start", st_cnt, 0);
    chk("arst_idle", state_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
